// File: rtl/bcd_addsub_serial_if.sv
// Start/done handshake and operand/result bus of the digit-serial BCD add/sub unit.
// Requester drives start/mode/cin/a/b; the unit drives busy/done/result/flags.
interface bcd_addsub_serial_if #(
   parameter int DIGITS = 2
);
   logic                  start;
   logic                  mode;
   logic                  cin;
   logic [4*DIGITS-1:0]   a;
   logic [4*DIGITS-1:0]   b;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   result;
   logic                  cout;
   logic                  neg;
   logic                  err;

   modport master (
      output start, mode, cin, a, b,
      input  busy, done, result, cout, neg, err
   );

   modport slave (
      input  start, mode, cin, a, b,
      output busy, done, result, cout, neg, err
   );
endinterface

// File: rtl/bcd_addsub_serial.sv
// Digit-serial N-digit packed-BCD adder/subtractor: one digit per clock, LSD first,
// one shared digit adder; negative differences get a recomplement (FIX) pass.
module bcd_addsub_serial #(
   parameter int DIGITS = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   bcd_addsub_serial_if.slave   bus,
   output logic [1:0]           dbg_state
);
   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state;
   logic [W-1:0]    a_r, b_r, res_r;
   logic            mode_r, carry, cout_r, neg_r, err_r;
   logic [IW-1:0]   idx;

   logic [IW+1:0]   sh;
   logic [3:0]      a_dig, b_dig, r_dig, x, y, dig;
   logic [4:0]      s;
   logic            c_out;
   logic            bad_in;
   logic [W-1:0]    res_next;

   // Shared digit adder: ADD sums a_i with b_i (or 9-b_i); FIX forms (9-r_i)+carry.
   always_comb begin
      sh    = {idx, 2'b00};
      a_dig = 4'(a_r >> sh);
      b_dig = 4'(b_r >> sh);
      r_dig = 4'(res_r >> sh);
      x     = (state == FIX) ? (4'd9 - r_dig) : a_dig;
      y     = (state == FIX) ? 4'd0 : (mode_r ? (4'd9 - b_dig) : b_dig);
      s     = {1'b0, x} + {1'b0, y} + {4'b0000, carry};
      c_out = (s > 5'd9);
      dig   = c_out ? 4'(s + 5'd6) : s[3:0];
      res_next = (res_r & ~(W'(4'hf) << sh)) | (W'(dig) << sh);
   end

   always_comb begin
      bad_in = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bus.a[i*4 +: 4] > 4'd9) bad_in = 1'b1;
         if (bus.b[i*4 +: 4] > 4'd9) bad_in = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_r    <= '0;
         b_r    <= '0;
         res_r  <= '0;
         mode_r <= 1'b0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         neg_r  <= 1'b0;
         err_r  <= 1'b0;
         idx    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_r    <= bus.a;
                  b_r    <= bus.b;
                  mode_r <= bus.mode;
                  carry  <= bus.mode ? 1'b1 : bus.cin;
                  idx    <= '0;
                  res_r  <= '0;
                  cout_r <= 1'b0;
                  neg_r  <= 1'b0;
                  err_r  <= bad_in;
                  state  <= ADD;
               end
            end
            ADD: begin
               // A rejected operand spends one ADD cycle idle so the error path has fixed latency.
               if (err_r) begin
                  state <= DONE;
               end else begin
                  res_r <= res_next;
                  carry <= c_out;
                  if (idx == LAST) begin
                     idx <= '0;
                     if (mode_r && !c_out) begin
                        neg_r <= 1'b1;
                        carry <= 1'b1;
                        state <= FIX;
                     end else begin
                        cout_r <= !mode_r && c_out;
                        state  <= DONE;
                     end
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
            end
            FIX: begin
               res_r <= res_next;
               carry <= c_out;
               if (idx == LAST) begin
                  idx   <= '0;
                  state <= DONE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy   = (state != IDLE);
   assign bus.done   = (state == DONE);
   assign bus.result = res_r;
   assign bus.cout   = cout_r;
   assign bus.neg    = neg_r;
   assign bus.err    = err_r;
   assign dbg_state  = state;
endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Directed + random bench for bcd_addsub_serial (DIGITS=2): decimal reference model,
// expected-result queue, latency and handshake checks, reset mid-operation.
module tb_bcd_addsub_serial;
   localparam int D = 2;
   localparam int W = 4 * D;

   logic       clk;
   logic       rst;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W+2:0] exp_q[$];
   int           lat_q[$];

   bcd_addsub_serial_if #(.DIGITS(D)) bus ();

   bcd_addsub_serial #(.DIGITS(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no end of test, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Decimal reference: returns {result, cout, neg, err} and the expected latency.
   function automatic logic [W+2:0] model(input logic m, input logic c,
                                          input logic [W-1:0] av, input logic [W-1:0] bv,
                                          output int lat);
      int va, vb, r;
      logic bad, co, ng;
      logic [W-1:0] rb;
      bad = (av[7:4] > 4'd9) || (av[3:0] > 4'd9) || (bv[7:4] > 4'd9) || (bv[3:0] > 4'd9);
      va = int'(av[7:4]) * 10 + int'(av[3:0]);
      vb = int'(bv[7:4]) * 10 + int'(bv[3:0]);
      co = 1'b0;
      ng = 1'b0;
      if (bad) begin
         r = 0;
         lat = 1;
      end else if (!m) begin
         r = va + vb + int'(c);
         co = (r >= 100);
         r = r % 100;
         lat = D;
      end else begin
         r = va - vb;
         ng = (r < 0);
         if (ng) r = -r;
         lat = ng ? 2 * D : D;
      end
      rb = {4'(r / 10), 4'(r % 10)};
      return {rb, co, ng, bad};
   endfunction

   task automatic run_op(input logic m, input logic c, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input bit poke);
      int lat, n, extra;
      logic [W+2:0] e;
      logic [W+2:0] obs;
      exp_q.push_back(model(m, c, av, bv, lat));
      lat_q.push_back(lat);
      @(negedge clk);
      bus.start = 1'b1;
      bus.mode  = m;
      bus.cin   = c;
      bus.a     = av;
      bus.b     = bv;
      @(posedge clk);
      #1;
      check("busy_rise", bus.busy, 1);
      if (poke) begin
         bus.a    = 8'h11;
         bus.b    = 8'h22;
         bus.mode = ~m;
      end else begin
         bus.start = 1'b0;
      end
      for (n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (bus.done) break;
      end
      bus.start = 1'b0;
      e   = exp_q.pop_front();
      lat = lat_q.pop_front();
      if (n > 20) begin
         check("done_timeout", 0, 1);
         return;
      end
      obs = {bus.result, bus.cout, bus.neg, bus.err};
      check("result", obs[W+2:3], e[W+2:3]);
      check("cout", obs[2], e[2]);
      check("neg", obs[1], e[1]);
      check("err", obs[0], e[0]);
      check("latency", n, lat);
      extra = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) extra++;
         if (i == 0) check("busy_fall", bus.busy, 0);
      end
      check("single_done", extra, 0);
      check("result_hold", {bus.result, bus.cout, bus.neg, bus.err}, e);
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.mode  = 1'b0;
      bus.cin   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_outs", {bus.result, bus.cout, bus.neg, bus.err}, 0);
      check("rst_state", dbg_state, 0);
      @(negedge clk);
      rst = 1'b0;

      run_op(1'b0, 1'b0, 8'h45, 8'h38, 1'b0);
      run_op(1'b0, 1'b1, 8'h99, 8'h99, 1'b0);
      run_op(1'b1, 1'b0, 8'h52, 8'h17, 1'b0);
      run_op(1'b1, 1'b0, 8'h17, 8'h52, 1'b0);
      run_op(1'b1, 1'b0, 8'h09, 8'h09, 1'b0);
      run_op(1'b1, 1'b0, 8'h00, 8'h99, 1'b0);
      run_op(1'b0, 1'b0, 8'h01, 8'h09, 1'b0);
      run_op(1'b1, 1'b1, 8'h52, 8'h17, 1'b0);
      run_op(1'b1, 1'b1, 8'h17, 8'h52, 1'b0);
      run_op(1'b0, 1'b0, 8'h1A, 8'h05, 1'b0);
      run_op(1'b0, 1'b0, 8'h20, 8'h30, 1'b0);
      run_op(1'b1, 1'b0, 8'h05, 8'hB0, 1'b0);
      run_op(1'b0, 1'b0, 8'h45, 8'h38, 1'b1);
      run_op(1'b1, 1'b0, 8'h17, 8'h52, 1'b1);

      for (int k = 0; k < 8; k++) begin
         logic [W-1:0] ra, rb;
         ra = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb, 1'b0);
      end

      // Reset while the FIX pass of 0x17-0x52 is in flight.
      @(negedge clk);
      bus.start = 1'b1;
      bus.mode  = 1'b1;
      bus.cin   = 1'b0;
      bus.a     = 8'h17;
      bus.b     = 8'h52;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("in_fix", dbg_state, 2);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_busy", bus.busy, 0);
      check("midrst_done", bus.done, 0);
      check("midrst_result", bus.result, 0);
      check("midrst_neg", bus.neg, 0);
      @(negedge clk);
      rst = 1'b0;
      run_op(1'b0, 1'b0, 8'h12, 8'h34, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
